ub_dma_engine: RTL

//  DMA initiator for the UnifiedBuffer (UB) DMA port: drives dma_write_en/dma_read_en/dma_addr/dma_data_in and consumes dma_data_out.
//  A command moves LEN consecutive words between a DRAM-side valid/ready stream and UB addresses starting at UB_ADDR.

---
 rtl/ub_dma_engine.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ub_dma_engine.sv
// rtl/ub_dma_engine.sv - DMA initiator moving words between a DRAM valid/ready stream and the UnifiedBuffer DMA port
module ub_dma_engine #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int LEN_W      = 11,
  parameter int UB_RD_LAT  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [ADDR_W-1:0] cmd_ub_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              busy,
  output logic              done,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [DATA_W-1:0] wr_data,
  output logic              dma_write_en,
  output logic              dma_read_en,
  output logic [ADDR_W-1:0] dma_addr,
  output logic [DATA_W-1:0] dma_data_in,
  input  logic [DATA_W-1:0] dma_data_out
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STORE, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_cnt;
  logic [LEN_W-1:0]  remaining;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  in_flight;
  logic [UB_RD_LAT-1:0] rd_pipe;

  logic            load_beat;
  logic            issue;
  logic            land;
  logic            pop;
  logic [CNT_W:0]  occupancy;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign rd_ready  = (state == S_LOAD) && (remaining != '0);
  assign wr_valid  = (fifo_count != '0);
  assign wr_data   = wr_valid ? fifo_mem[rd_ptr] : '0;

  // Reads are only issued when a FIFO slot is already reserved for their return.
  assign load_beat = rd_valid && rd_ready;
  assign occupancy = {1'b0, in_flight} + {1'b0, fifo_count};
  assign issue     = (state == S_STORE) && (remaining != '0) && (occupancy < DEPTH_LIM);
  assign land      = rd_pipe[UB_RD_LAT-1];
  assign pop       = wr_valid && wr_ready;

  always_ff @(posedge clk) begin
    if (land) fifo_mem[wr_ptr] <= dma_data_out;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      addr_cnt     <= '0;
      remaining    <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      in_flight    <= '0;
      rd_pipe      <= '0;
      dma_write_en <= 1'b0;
      dma_read_en  <= 1'b0;
      dma_addr     <= '0;
      dma_data_in  <= '0;
    end else begin
      dma_write_en <= load_beat;
      dma_read_en  <= issue;
      if (load_beat) begin
        dma_addr    <= addr_cnt;
        dma_data_in <= rd_data;
      end else if (issue) begin
        dma_addr <= addr_cnt;
      end
      if (load_beat || issue) begin
        addr_cnt  <= addr_cnt + ADDR_W'(1);
        remaining <= remaining - LEN_W'(1);
      end

      // Tracks each issued read until its data is valid on dma_data_out.
      rd_pipe[0] <= dma_read_en;
      for (int i = 1; i < UB_RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];

      if (land) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({land, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      case ({issue, land})
        2'b10:   in_flight <= in_flight + CNT_W'(1);
        2'b01:   in_flight <= in_flight - CNT_W'(1);
        default: in_flight <= in_flight;
      endcase

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_cnt  <= cmd_ub_addr;
            remaining <= cmd_len;
            if (cmd_len == '0) state <= S_DONE;
            else               state <= cmd_dir ? S_STORE : S_LOAD;
          end
        end
        S_LOAD:  if (remaining == '0) state <= S_DONE;
        S_STORE: if (remaining == '0) state <= S_DRAIN;
        S_DRAIN: if (in_flight == '0 && fifo_count == '0) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
